// File: rtl/fas_peak_detect.sv
// Peak-bin detector: captures one 16-bin FFT frame and scans one bin per clock
// for the largest magnitude. Define FAS_PEAK_ABS_EN to use |re|+|im| instead of re^2+im^2.
module fas_peak_detect #(
  parameter int DW   = 16,
  parameter int NBIN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            done,
  output logic [3:0]      freq,
  output logic            busy
);

`ifdef FAS_PEAK_ABS_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = 2*DW + 1;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state, state_next;
  logic [2*DW-1:0]   words [NBIN];
  logic [2*DW-1:0]   frame [NBIN];
  logic [3:0]        cnt;
  logic [MW-1:0]     max_mag, mag, max_next;
  logic [3:0]        max_idx, idx_next;
  logic signed [DW-1:0] re, im;
  logic              accept, last;

  always_comb begin
    words[0]  = fft_d0;  words[1]  = fft_d1;  words[2]  = fft_d2;  words[3]  = fft_d3;
    words[4]  = fft_d4;  words[5]  = fft_d5;  words[6]  = fft_d6;  words[7]  = fft_d7;
    words[8]  = fft_d8;  words[9]  = fft_d9;  words[10] = fft_d10; words[11] = fft_d11;
    words[12] = fft_d12; words[13] = fft_d13; words[14] = fft_d14; words[15] = fft_d15;
  end

  assign accept = fft_valid && (state == IDLE || state == DONE);
  assign last   = (cnt == 4'(NBIN - 1));

  assign re = frame[cnt][2*DW-1:DW];
  assign im = frame[cnt][DW-1:0];

`ifdef FAS_PEAK_ABS_EN
  logic [DW:0] re_x, im_x, re_abs, im_abs;
  always_comb begin
    re_x   = {re[DW-1], re};
    im_x   = {im[DW-1], im};
    // one extra bit so that |-2^(DW-1)| is exact
    re_abs = re[DW-1] ? (~re_x + (DW+1)'(1)) : re_x;
    im_abs = im[DW-1] ? (~im_x + (DW+1)'(1)) : im_x;
    mag    = re_abs + im_abs;
  end
`else
  logic signed [2*DW-1:0] re_sq, im_sq;
  always_comb begin
    re_sq = re * re;
    im_sq = im * im;
    // squares are non-negative; zero-extend so the sum never overflows
    mag   = {1'b0, re_sq} + {1'b0, im_sq};
  end
`endif

  always_comb begin
    max_next = max_mag;
    idx_next = max_idx;
    if (cnt == '0 || mag > max_mag) begin
      max_next = mag;
      idx_next = cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fft_valid) state_next = SCAN;
      SCAN:    if (last)      state_next = DONE;
      DONE:    state_next = fft_valid ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done = (state == DONE);
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      max_mag <= '0;
      max_idx <= '0;
      freq    <= '0;
      for (int unsigned k = 0; k < NBIN; k++) frame[k] <= '0;
    end else begin
      if (accept) begin
        for (int unsigned k = 0; k < NBIN; k++) frame[k] <= words[k];
        cnt <= '0;
      end
      if (state == SCAN) begin
        cnt     <= cnt + 4'd1;
        max_mag <= max_next;
        max_idx <= idx_next;
        // load freq on the final bin so it is already valid in the DONE cycle
        if (last) freq <= idx_next;
      end
    end
  end

endmodule

// File: tb/tb_fas_peak_detect.sv
// Self-checking bench for fas_peak_detect: directed table, corner sequences and
// random frames checked against a behavioural peak model.
module tb_fas_peak_detect;

  typedef logic [31:0] frame_t [16];
  typedef struct {
    string  name;
    frame_t d;
    int     exp_freq;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  frame_t      d;
  logic        done;
  logic [3:0]  freq;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fas_peak_detect #(.DW(16), .NBIN(16)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: first bin with the largest magnitude wins.
  function automatic int model_peak(input frame_t w);
    longint best = -1;
    int idx = 0;
    for (int i = 0; i < 16; i++) begin
      int re, im;
      longint m;
      re = $signed(w[i][31:16]);
      im = $signed(w[i][15:0]);
`ifdef FAS_PEAK_ABS_EN
      m = longint'(re < 0 ? -re : re) + longint'(im < 0 ? -im : im);
`else
      m = longint'(re) * re + longint'(im) * im;
`endif
      if (m > best) begin
        best = m;
        idx  = i;
      end
    end
    return idx;
  endfunction

  function automatic frame_t zero_frame();
    frame_t f;
    for (int i = 0; i < 16; i++) f[i] = '0;
    return f;
  endfunction

  function automatic frame_t peak_frame(input int bin, input logic [15:0] re);
    frame_t f;
    f = zero_frame();
    f[bin] = {re, 16'h0000};
    return f;
  endfunction

  // Drive one frame and follow it through to done with exact cycle checks.
  task automatic run_frame(input string name, input frame_t f, input int exp_freq);
    @(negedge clk);
    d = f;
    fft_valid = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      fft_valid = 1'b0;
      check({name, ".busy"}, int'(busy), 1);
      check({name, ".done"}, int'(done), (k == 17) ? 1 : 0);
      if (k == 17) check({name, ".freq"}, int'(freq), exp_freq);
    end
    @(negedge clk);
    check({name, ".idle_busy"}, int'(busy), 0);
    check({name, ".idle_freq"}, int'(freq), exp_freq);
  endtask

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fa, fb, fc;
    bit seen_done;

    tbl[0].name = "single_peak"; tbl[0].d = peak_frame(5, 16'sd100); tbl[0].exp_freq = 5;
    tbl[1].name = "tie_sign";    tbl[1].d = zero_frame();
    tbl[1].d[3] = {-16'sd300, 16'sd400}; tbl[1].d[9] = {16'sd500, 16'sd0}; tbl[1].exp_freq = 3;
    tbl[2].name = "corner";      tbl[2].d = zero_frame();
    tbl[2].d[15] = {16'h8000, 16'h8000}; tbl[2].d[0] = {16'h7FFF, 16'h7FFF}; tbl[2].exp_freq = 15;
    tbl[3].name = "all_zero";    tbl[3].d = zero_frame(); tbl[3].exp_freq = 0;
    tbl[4].name = "exact_tie";   tbl[4].d = zero_frame();
    tbl[4].d[4] = {16'sd100, 16'sd0}; tbl[4].d[12] = {16'sd0, -16'sd100}; tbl[4].exp_freq = 4;
    tbl[5].name = "neg_only";    tbl[5].d = zero_frame();
    tbl[5].d[1] = {-16'sd2, -16'sd2}; tbl[5].d[14] = {16'sd0, -16'sd900}; tbl[5].exp_freq = 14;

    rst = 1'b1;
    fft_valid = 1'b0;
    d = zero_frame();
    repeat (2) @(negedge clk);
    check("reset.done", int'(done), 0);
    check("reset.freq", int'(freq), 0);
    check("reset.busy", int'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(tbl[i].name, tbl[i].d, tbl[i].exp_freq);

    // Reset in the middle of a scan
    run_frame("pre_reset", peak_frame(9, 16'sd77), 9);
    @(negedge clk);
    d = peak_frame(13, 16'sd50);
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.busy", int'(busy), 0);
    check("midrst.freq", int'(freq), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("midrst.no_done", int'(seen_done), 0);
    check("midrst.freq_after", int'(freq), 0);
    check("midrst.busy_after", int'(busy), 0);
    run_frame("post_reset", peak_frame(6, -16'sd1234), 6);

    // Back-to-back accept in DONE, drop during SCAN
    fa = peak_frame(2, 16'sd1000);
    fb = peak_frame(7, 16'sd3000);
    fc = peak_frame(11, 16'sd500);
    @(negedge clk);
    d = fa;
    fft_valid = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      fft_valid = (k == 8 || k == 17);
      if (k == 8)  d = fb;
      if (k == 17) d = fc;
      check("b2b.busy", int'(busy), 1);
      check("b2b.done", int'(done), (k == 17 || k == 34) ? 1 : 0);
      if (k >= 17 && k <= 33) check("b2b.freq_hold", int'(freq), 2);
      if (k == 34) check("b2b.freq_c", int'(freq), 11);
    end
    @(negedge clk);
    fft_valid = 1'b0;
    check("b2b.idle", int'(busy), 0);

    // Random frames against the model
    for (int n = 0; n < 30; n++) begin
      frame_t f;
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 4))
          0:       f[i] = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
          1:       f[i] = {16'h8000, 16'($urandom)};
          2:       f[i] = '0;
          default: f[i] = $urandom;
        endcase
      end
      run_frame("random", f, model_peak(f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
